// File: rtl/mux_arbiter_pkg.sv
// Shared types and constants for the two-source mux arbiter.
package mux_arb_pkg;

  localparam int unsigned CNT_W_DEF = 4;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mux.sv
// Registered 2:1 mux datapath shared by the two sources; y follows sel one edge later.
module mux #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] y
);

  always_ff @(posedge clk) begin
    y <= sel ? b : a;
  end

endmodule

// File: rtl/mux_arbiter_rr_pick2.sv
// Two-way round-robin pick: on a tie the requester that did not win last time wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic win_valid,
  output logic win_id
);

  always_comb begin
    win_valid = req0 | req1;
    win_id    = 1'b0;
    if (req0 && req1) begin
      win_id = ~last;
    end else if (req1) begin
      win_id = 1'b1;
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin burst arbiter driving the shared mux select, with valid/source tags aligned to y.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [CNT_W-1:0] len0,
  input  logic [CNT_W-1:0] len1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic             busy,
  output logic             out_valid,
  output logic             out_src
);

  arb_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] win_len;
  logic             owner, owner_n;
  logic             last, last_n;
  logic             sel_n;
  logic             arb_point;
  logic             win_valid;
  logic             win_id;

  rr_pick2 u_pick (
    .req0      (req0),
    .req1      (req1),
    .last      (last),
    .win_valid (win_valid),
    .win_id    (win_id)
  );

  assign busy = (state == BURST);
  assign gnt0 = busy & (owner == SRC_A);
  assign gnt1 = busy & (owner == SRC_B);

  // Re-arbitrating on the final burst cycle gives back-to-back bursts with no bubble.
  assign arb_point = (state == IDLE) || (cnt == CNT_W'(1));

  always_comb begin
    win_len = (win_id == SRC_B) ? len1 : len0;
    if (win_len == '0) begin
      win_len = CNT_W'(1);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    owner_n = owner;
    last_n  = last;
    sel_n   = sel;

    if (state == BURST) begin
      cnt_n = cnt - CNT_W'(1);
    end

    if (arb_point) begin
      if (win_valid) begin
        state_n = BURST;
        cnt_n   = win_len;
        owner_n = win_id;
        last_n  = win_id;
        sel_n   = win_id;
      end else begin
        state_n = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      owner <= SRC_A;
      last  <= SRC_B;
      sel   <= SRC_A;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      owner <= owner_n;
      last  <= last_n;
      sel   <= sel_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_src   <= SRC_A;
    end else begin
      out_valid <= busy;
      out_src   <= owner;
    end
  end

  a_cnt_live: assert property (@(posedge clk) disable iff (!rst_n)
    (state == BURST) |-> (cnt != '0));

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(gnt0 && gnt1));

endmodule
